regfile_write_arbiter: RTL

- Shares the register file's single write port (rd, write_data, reg_write, label_write) between two requesters.
- Requester 1 is the core writeback stage; requester 2 is the loader/debug port that initialises label and general registers over a valid/ready handshake.
- Core writeback has fixed priority. A starvation counter forces a loader grant and stalls the core for one cycle.
- Outputs are registered and drive the register file write controls directly.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/starve_counter.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;

    typedef enum logic [0:0] {
        ARB,
        FORCE
    } arb_state_t;

    localparam int unsigned NUM_REGS = 6;

    localparam logic BANK_GEN = 1'b0;
    localparam logic BANK_LBL = 1'b1;

    typedef struct packed {
        logic [2:0] rd;
        logic [7:0] data;
        logic       label;
    } wr_req_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter; full_o flags that the count will sit at Limit after this edge.
module starve_counter #(
    parameter int unsigned Limit = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic full_o
);

    localparam logic [3:0] LimitW = 4'(Limit);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LimitW)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Looking at the next value lets the arbiter enter FORCE on the very edge the limit is hit.
    assign full_o = (count_d == LimitW);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between core writeback (priority)
// and the loader port, with a starvation-forced loader slot that stalls the core.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned NUM_REGS     = regfile_pkg::NUM_REGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_valid,
    input  logic [2:0] wb_rd,
    input  logic [7:0] wb_data,
    input  logic       wb_label,
    output logic       core_stall,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [2:0] ld_rd,
    input  logic [7:0] ld_data,
    input  logic       ld_label,
    output logic [2:0] rd,
    output logic [7:0] write_data,
    output logic       reg_write,
    output logic       label_write,
    output logic       addr_err
);

    import regfile_pkg::*;

    arb_state_t state_q, state_d;
    wr_req_t    wb_req, ld_req, gnt_req;
    logic       wb_gnt, ld_gnt, gnt_valid, in_range;
    logic       cnt_inc, cnt_clr, cnt_full;

    logic [2:0] rd_q;
    logic [7:0] data_q;
    logic       reg_write_q, label_write_q, addr_err_q;

    assign wb_req = '{rd: wb_rd, data: wb_data, label: wb_label};
    assign ld_req = '{rd: ld_rd, data: ld_data, label: ld_label};

    starve_counter #(
        .Limit(STARVE_LIMIT)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .full_o(cnt_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FORCE is always a single cycle.
    always_comb begin
        state_d = ARB;
        if (state_q == ARB && cnt_full) begin
            state_d = FORCE;
        end
    end

    always_comb begin
        wb_gnt  = 1'b0;
        ld_gnt  = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            ARB: begin
                if (wb_valid) begin
                    wb_gnt  = 1'b1;
                    cnt_inc = ld_valid;
                    cnt_clr = !ld_valid;
                end else begin
                    ld_gnt  = ld_valid;
                    cnt_clr = 1'b1;
                end
            end
            FORCE: begin
                ld_gnt  = ld_valid;
                cnt_clr = 1'b1;
            end
        endcase
    end

    assign core_stall = (state_q == FORCE);
    assign ld_ready   = ld_gnt && !reset;
    assign gnt_valid  = wb_gnt || ld_gnt;
    assign gnt_req    = ld_gnt ? ld_req : wb_req;
    assign in_range   = 32'(gnt_req.rd) < NUM_REGS;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q          <= '0;
            data_q        <= '0;
            reg_write_q   <= 1'b0;
            label_write_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            reg_write_q   <= gnt_valid && in_range && (gnt_req.label == BANK_GEN);
            label_write_q <= gnt_valid && in_range && (gnt_req.label == BANK_LBL);
            if (gnt_valid) begin
                rd_q   <= gnt_req.rd;
                data_q <= gnt_req.data;
            end
            if (gnt_valid && !in_range) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign rd          = rd_q;
    assign write_data  = data_q;
    assign reg_write   = reg_write_q;
    assign label_write = label_write_q;
    assign addr_err    = addr_err_q;

endmodule
